lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles waiting for mem_ack before a timeout fault (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  CPU access request; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 func3  input  3  RISC-V load/store width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, low-aligned.
REQ-009 busy  output  1  high whenever state is not IDLE; CPU stalls on it.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 rdata  output  32  load data shifted so the addressed byte sits at bit 0; feeds the sign-extension stage.
REQ-012 func3_out  output  3  latched func3, valid with done.
REQ-013 fault  output  1  one-cycle pulse on a faulted access.
REQ-014 fault_code  output  2  01 misaligned, 10 illegal func3, 11 timeout; valid with fault.
REQ-015 mem_req, mem_we  output  1 each  memory request and direction.
REQ-016 mem_addr  output  32  word address ({addr[31:2],2'b00}).
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_wstrb  output  4  byte write strobes; 0000 on loads.
REQ-019 mem_ack  input  1  memory completion; mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-020 FSM states IDLE, ACCESS, RESP, FAULT; IDLE->ACCESS on valid req; ACCESS->RESP on mem_ack; RESP->IDLE and FAULT->IDLE unconditionally.
REQ-021 On accept, we, func3, addr[1:0], addr and wdata shall be latched; inputs thereafter ignored until IDLE.
REQ-022 req in IDLE with illegal func3 (011,110,111; or store with func3[2]=1) -> FAULT, code 10, no memory access.
REQ-023 req with half access and addr[0]=1, or word access and addr[1:0]!=00 -> FAULT, code 01, no memory access; illegal func3 takes priority.
REQ-024 mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb shall be driven registered and held stable throughout ACCESS, mem_req low in all other states.
REQ-025 Store lanes: byte -> mem_wdata={4{wdata[7:0]}}, mem_wstrb=0001<<addr[1:0]; half -> {2{wdata[15:0]}}, 0011 or 1100 by addr[1]; word -> wdata, 1111.
REQ-026 Load: rdata = mem_rdata >> (8*addr[1:0]), zero-filled, registered on mem_ack and held until next accepted load.
REQ-027 done pulses in RESP (one cycle after mem_ack); fault pulses in FAULT; done and fault never high together.
REQ-028 mem_ack outside ACCESS shall be ignored.
REQ-029 Minimum latency with immediate ack: req at cycle N, mem_req at N+1, done at N+2.
REQ-030 busy deasserts in the cycle after done/fault; back-to-back req then accepted.

Reset
REQ-031 rst_n low shall immediately force IDLE; busy, done, fault, mem_req, mem_we = 0; fault_code, mem_wstrb = 0; rdata, mem_addr, mem_wdata, func3_out = 0; timeout counter = 0.
REQ-032 Reset mid-ACCESS shall drop mem_req asynchronously; no done or fault is generated for the aborted access.

Configuration
REQ-033 Macro LSU_TIMEOUT_EN: when defined, an 8-bit counter runs in ACCESS; reaching TIMEOUT_CYCLES without mem_ack -> FAULT, code 11, mem_req dropped; ack in the same cycle as expiry wins (RESP).
REQ-034 Without LSU_TIMEOUT_EN, no counter is built and ACCESS waits indefinitely for mem_ack; code 11 never produced.

Verification
REQ-035 sb, addr=0x1003, wdata=0x000000AB, ack after 2 cycles -> mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=1000, done once.
REQ-036 lh, addr=0x2002, mem_rdata=0x8765_4321 -> rdata=0x0000_8765, func3_out=001, done at cycle N+2 with immediate ack.
REQ-037 lw addr=0x3001 -> fault, code 01, mem_req never asserted; func3=011 -> code 10.
REQ-038 LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> fault code 11 after 4 ACCESS cycles; undefined -> busy held indefinitely.
REQ-039 rst_n pulsed low during ACCESS -> mem_req low same cycle, no done; later sw addr=0x10 completes normally with mem_wstrb=1111.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: CPU-side and memory-side bus bundle for the load/store controller.
interface lsu_mem_ctrl_if;
   logic        req;
   logic        we;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic [2:0]  func3_out;
   logic        fault;
   logic [1:0]  fault_code;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   modport slave (
      input  req, we, func3, addr, wdata, mem_ack, mem_rdata,
      output busy, done, rdata, func3_out, fault, fault_code,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
   modport master (
      output req, we, func3, addr, wdata, mem_ack, mem_rdata,
      input  busy, done, rdata, func3_out, fault, fault_code,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RISC-V load/store memory access FSM; LSU_TIMEOUT_EN adds an ack timeout fault.
module lsu_mem_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           rst_n,
   lsu_mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;
   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic        mreq_q, mreq_d;
   logic [2:0]  func3_q, func3_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  code_q, code_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwd_q, mwd_d;
   logic [31:0] rdata_q, rdata_d;
   logic        illegal, misaligned, expire;
   assign illegal    = (bus.func3 inside {3'b011, 3'b110, 3'b111}) || (bus.we && bus.func3[2]);
   assign misaligned = (bus.func3[1:0] == 2'b01 && bus.addr[0]) ||
                       (bus.func3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
`ifdef LSU_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign cnt_d  = (state_q == ACCESS) ? cnt_q + 8'd1 : 8'd0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign expire = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      mreq_d  = mreq_q;
      func3_d = func3_q;
      off_d   = off_q;
      code_d  = code_q;
      wstrb_d = wstrb_q;
      maddr_d = maddr_q;
      mwd_d   = mwd_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (bus.req) begin
            state_d = (illegal || misaligned) ? FAULT : ACCESS;
            mreq_d  = !(illegal || misaligned);
            code_d  = illegal ? 2'b10 : 2'b01;
            we_d    = bus.we;
            func3_d = bus.func3;
            off_d   = bus.addr[1:0];
            maddr_d = {bus.addr[31:2], 2'b00};
            mwd_d   = bus.func3[1] ? bus.wdata :
                      bus.func3[0] ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};
            wstrb_d = !bus.we      ? 4'b0000 :
                      bus.func3[1] ? 4'b1111 :
                      bus.func3[0] ? (bus.addr[1] ? 4'b1100 : 4'b0011) :
                                     4'b0001 << bus.addr[1:0];
         end
         ACCESS: if (bus.mem_ack) begin
            state_d = RESP;
            mreq_d  = 1'b0;
            rdata_d = we_q ? rdata_q : bus.mem_rdata >> {off_q, 3'b000};
         end else if (expire) begin
            state_d = FAULT;
            mreq_d  = 1'b0;
            code_d  = 2'b11;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         mreq_q  <= 1'b0;
         func3_q <= '0;
         off_q   <= '0;
         code_q  <= '0;
         wstrb_q <= '0;
         maddr_q <= '0;
         mwd_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         mreq_q  <= mreq_d;
         func3_q <= func3_d;
         off_q   <= off_d;
         code_q  <= code_d;
         wstrb_q <= wstrb_d;
         maddr_q <= maddr_d;
         mwd_q   <= mwd_d;
         rdata_q <= rdata_d;
      end
   assign bus.busy       = state_q != IDLE;
   assign bus.done       = state_q == RESP;
   assign bus.fault      = state_q == FAULT;
   assign bus.fault_code = code_q;
   assign bus.func3_out  = func3_q;
   assign bus.rdata      = rdata_q;
   assign bus.mem_req    = mreq_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = maddr_q;
   assign bus.mem_wdata  = mwd_q;
   assign bus.mem_wstrb  = wstrb_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and random load/store transactions against a lane-level reference model.
module tb_lsu_mem_ctrl;
   localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
   localparam int HOLD = 2;
`else
   localparam int HOLD = 30;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   logic [31:0] last_rd = '0;
   lsu_mem_ctrl_if bus();
   lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a, wd, mrd,
                                 output int code, output bit [31:0] e_addr, e_wd, e_rd,
                                 output bit [3:0] e_st);
      int size, off;
      bit ill;
      ill    = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3 > 3'd2);
      size   = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      off    = int'(a % 4);
      code   = ill ? 2 : (a % size != 0) ? 1 : 0;
      e_addr = a - a % 4;
      e_rd   = mrd >> (8 * off);
      for (int i = 0; i < 4; i++) begin
         e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
         e_st[i] = we && i >= off && i < off + size;
      end
   endfunction
   task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] a, wd, mrd, input int dly);
      int code;
      bit [31:0] e_addr, e_wd, e_rd;
      bit [3:0] e_st;
      model(we, f3, a, wd, mrd, code, e_addr, e_wd, e_rd, e_st);
      chk("idle_busy", bus.busy, 0);
      bus.req = 1'b1; bus.we = we; bus.func3 = f3; bus.addr = a; bus.wdata = wd;
      tick();
      bus.req = 1'b0; bus.we = 1'($urandom); bus.func3 = 3'($urandom);
      bus.addr = $urandom; bus.wdata = $urandom;
      chk("accept_done", bus.done, 0);
      chk("accept_busy", bus.busy, 1);
      if (code != 0) begin
         chk("fault", bus.fault, 1);
         chk("fault_code", bus.fault_code, code);
         chk("fault_mem_req", bus.mem_req, 0);
         tick();
         chk("fault_clear", bus.fault, 0);
         chk("fault_busy_clear", bus.busy, 0);
      end else begin
         for (int c = 0; c <= dly; c++) begin
            chk("mem_req", bus.mem_req, 1);
            chk("mem_we", bus.mem_we, we);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wstrb", bus.mem_wstrb, e_st);
            if (we) chk("mem_wdata", bus.mem_wdata, e_wd);
            chk("access_done", bus.done, 0);
            chk("access_fault", bus.fault, 0);
            bus.mem_ack = (c == dly);
            bus.mem_rdata = (c == dly) ? mrd : $urandom;
            tick();
         end
         bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
         if (!we) last_rd = e_rd;
         chk("done", bus.done, 1);
         chk("resp_fault", bus.fault, 0);
         chk("resp_mem_req", bus.mem_req, 0);
         chk("func3_out", bus.func3_out, f3);
         chk("rdata", bus.rdata, last_rd);
         tick();
         chk("done_clear", bus.done, 0);
         chk("busy_clear", bus.busy, 0);
         chk("rdata_hold", bus.rdata, last_rd);
      end
   endtask
   initial begin
      bus.req = 0; bus.we = 0; bus.func3 = 0; bus.addr = 0; bus.wdata = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_fault_code", bus.fault_code, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_wstrb", bus.mem_wstrb, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_func3_out", bus.func3_out, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      txn(1, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0, 2);
      txn(0, 3'b001, 32'h2002, 32'h0, 32'h8765_4321, 0);
      txn(0, 3'b010, 32'h3001, 32'h0, 32'h0, 0);
      txn(0, 3'b011, 32'h3000, 32'h0, 32'h0, 0);
      txn(1, 3'b100, 32'h3000, 32'h0, 32'h0, 0);
      txn(0, 3'b101, 32'h3003, 32'h0, 32'h0, 0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      tick();
      tick();
      bus.mem_ack = 1'b0;
      chk("stray_ack_busy", bus.busy, 0);
      chk("stray_ack_done", bus.done, 0);
      chk("stray_ack_rdata", bus.rdata, last_rd);
      for (int n = 0; n < 60; n++)
         txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom_range(0, 3));
`ifdef LSU_TIMEOUT_EN
      bus.req = 1'b1; bus.we = 1'b0; bus.func3 = 3'b010; bus.addr = 32'h80;
      tick();
      bus.req = 1'b0;
      for (int c = 1; c < TO; c++) begin
         chk("to_wait_mem_req", bus.mem_req, 1);
         chk("to_wait_fault", bus.fault, 0);
         tick();
      end
      chk("to_wait_last", bus.mem_req, 1);
      tick();
      chk("to_fault", bus.fault, 1);
      chk("to_code", bus.fault_code, 3);
      chk("to_mem_req", bus.mem_req, 0);
      tick();
      chk("to_busy_clear", bus.busy, 0);
`endif
      bus.req = 1'b1; bus.we = 1'b0; bus.func3 = 3'b010; bus.addr = 32'h40;
      tick();
      bus.req = 1'b0;
      for (int c = 0; c < HOLD; c++) begin
         chk("hold_busy", bus.busy, 1);
         chk("hold_mem_req", bus.mem_req, 1);
         chk("hold_done", bus.done, 0);
         chk("hold_fault", bus.fault, 0);
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_mem_req", bus.mem_req, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      @(negedge clk) rst_n = 1'b1;
      last_rd = '0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_abort_done", bus.done, 0);
         chk("post_abort_fault", bus.fault, 0);
         chk("post_abort_busy", bus.busy, 0);
      end
      txn(1, 3'b010, 32'h10, $urandom, 32'h0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
